occ_gt_link_tester: RTL and testbench
=====================================

# occ_gt_link_tester

Synthesizable link pattern generator and checker for OCC gigabit transceiver tiles (GTPE2/GTXE2), parametrised in word width, comma period and loss-of-lock threshold. The TX side emits a counter pattern with a periodic K28.5 comma. The RX side hunts for the comma, locks to the counter and counts word errors. It sits in the user-clock domain between the `occ_*_tile` user ports and the status/register bank, and provides in-system link BER checks.

## Interface
- `g_BYTES`, 2: bytes per word, 2 or 4; `W = 8*g_BYTES`.
- `g_COMMA_PERIOD_LOG2`, 5: comma every `P = 2^g_COMMA_PERIOD_LOG2` words; range 1..W-1.
- `g_LOSS_THRESH`, 4: consecutive bad words that force loss of lock; ≥1.
- `g_CNT_WIDTH`, 32: width of the saturating counters.
- `clk_i` in 1: user clock (tile `usrclk_o`).
- `rst_i` in 1: reset, asynchronous, active-high.
- `tx_data_o` out W: TX word.
- `tx_charisk_o` out g_BYTES: TX K flags.
- `rx_valid_i` in 1: RX word valid this cycle; checker idles when low.
- `rx_data_i` in W: RX word.
- `rx_charisk_i` in g_BYTES: RX K flags.
- `rx_disperr_i` in g_BYTES: disparity error flags.
- `rx_notintable_i` in g_BYTES: not-in-table flags.
- `clear_i` in 1: synchronous pulse that zeroes `err_cnt_o` and `word_cnt_o`.
- `locked_o` out 1: checker in LOCKED.
- `err_o` out 1: one-cycle pulse per bad word checked while LOCKED.
- `err_cnt_o` out g_CNT_WIDTH: bad words while LOCKED, saturating.
- `word_cnt_o` out g_CNT_WIDTH: words checked while LOCKED, saturating.

## Operation
- Comma word: MS byte 0xBC with K=1. Every other byte is 0x95 with K=0. For 2 bytes this is 0xBC95 / 2'b10.
- Generator: W-bit counter `c`, incremented every cycle and wrapping mod 2^W. Output is the comma word if `c mod P == 0`, else `c` with all K=0.
- Checker FSM, evaluated only when `rx_valid_i`=1:
  - HUNT: on an exact comma word (data and K flags both match) → SYNC.
  - SYNC: a data word `d` with K=0 and `d mod P == 1` loads `exp = d+1` and goes to LOCKED. Any other word → HUNT. No errors are counted in HUNT or SYNC.
  - LOCKED:
    - Expected word is the comma if `exp mod P == 0`, else `exp`, with all K=0.
    - A word is bad on a data or K mismatch, or if any `rx_disperr_i` / `rx_notintable_i` bit is set.
    - Each checked word increments `word_cnt`. A bad word also increments `err_cnt`, pulses `err_o` and increments the consecutive-bad counter; a good word clears the consecutive-bad counter.
    - `exp` advances by 1 on every checked word, good or bad, and wraps mod 2^W.
    - When the consecutive-bad count reaches `g_LOSS_THRESH` → HUNT.
- `rx_valid_i`=0: FSM, `exp` and counters hold.
- Counters saturate at all-ones.
- `clear_i` has priority over a same-cycle increment: the result is 0 and that event is lost.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); relock requires a fresh comma.

## Timing
- Reset values:
  - `tx_data_o` = comma word, `tx_charisk_o` = comma K pattern (c=0).
  - `locked_o`=0, `err_o`=0, `err_cnt_o`=0, `word_cnt_o`=0.
  - FSM=HUNT, consecutive-bad counter=0.
- TX: registered. After reset release, word n appears n cycles after the first active edge.
- RX: all outputs registered, one-cycle latency. A word sampled at edge k is reflected in `err_o` and the counters after edge k.
- `locked_o` rises the cycle after the SYNC data word is sampled. It falls the cycle after the `g_LOSS_THRESH`-th consecutive bad word is sampled, and that word is still counted.
- Minimum lock time from the first comma: 2 valid words.

## Structure
- Package `occ_gt_tester_pkg`: K28.5 byte 0xBC, filler byte 0x95, FSM state type (HUNT/SYNC/LOCKED), and a function that builds the comma word and K vector for a given `g_BYTES`.
- Sub-module `occ_gt_pattern_gen`: TX counter and comma insertion. The checker stays in the top level.

## Test plan
- Loopback TX→RX, `g_BYTES`=2, P=32, 10000 cycles → `locked_o`=1 within 2 words of the first comma, `err_cnt_o`=0, `word_cnt_o` equal to the number of words checked.
- Flip one bit of one data word while LOCKED → one `err_o` pulse, `err_cnt_o`=1, `locked_o` stays 1.
- Corrupt 4 consecutive words with `g_LOSS_THRESH`=4 → `err_cnt_o`=4, `locked_o` drops after the 4th word and relocks 2 valid words after the next comma.
- Assert `rx_disperr_i`=2'b01 on a correct word → counted as an error. Hold `rx_valid_i` low for 7 cycles → no counter or `exp` change.
- `g_BYTES`=4 with the TX counter forced near 0xFFFFFFFF → wrap to 0 yields a comma, no errors. Set `g_CNT_WIDTH`=4 and inject 20 errors → `err_cnt_o` saturates at 15.
- Pulse `clear_i` in the same cycle as a bad word → `err_cnt_o`=0 and `word_cnt_o`=0. Assert `rst_i` while LOCKED → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/occ_gt_link_tester_pkg.sv
// Shared constants, checker state encoding and comma builders for the GT link tester.
package occ_gt_tester_pkg;

  localparam logic [7:0] K28_5_BYTE = 8'hBC;
  localparam logic [7:0] FILL_BYTE  = 8'h95;
  localparam int         MAX_BYTES  = 4;

  typedef logic [1:0] chk_state_t;
  localparam chk_state_t ST_HUNT   = 2'd0;
  localparam chk_state_t ST_SYNC   = 2'd1;
  localparam chk_state_t ST_LOCKED = 2'd2;

  // Comma data word, LSB-aligned: K28.5 in the top used byte, filler below, zero above.
  function automatic logic [8*MAX_BYTES-1:0] comma_data(input int n_bytes);
    logic [8*MAX_BYTES-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < n_bytes - 1) w[8*i +: 8] = FILL_BYTE;
      else if (i == n_bytes - 1) w[8*i +: 8] = K28_5_BYTE;
    end
    return w;
  endfunction

  // K flags of the comma word: only the K28.5 byte is a control character.
  function automatic logic [MAX_BYTES-1:0] comma_k(input int n_bytes);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i == n_bytes - 1) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/occ_gt_link_tester_if.sv
// TX pattern, RX word stream and status bundle between the tile user ports and the tester.
interface occ_gt_link_tester_if #(
  parameter int g_BYTES     = 2,
  parameter int g_CNT_WIDTH = 32
);
  logic [8*g_BYTES-1:0]   tx_data_o;
  logic [g_BYTES-1:0]     tx_charisk_o;
  logic                   rx_valid_i;
  logic [8*g_BYTES-1:0]   rx_data_i;
  logic [g_BYTES-1:0]     rx_charisk_i;
  logic [g_BYTES-1:0]     rx_disperr_i;
  logic [g_BYTES-1:0]     rx_notintable_i;
  logic                   clear_i;
  logic                   locked_o;
  logic                   err_o;
  logic [g_CNT_WIDTH-1:0] err_cnt_o;
  logic [g_CNT_WIDTH-1:0] word_cnt_o;

  modport master (
    output tx_data_o, tx_charisk_o, locked_o, err_o, err_cnt_o, word_cnt_o,
    input  rx_valid_i, rx_data_i, rx_charisk_i, rx_disperr_i, rx_notintable_i, clear_i
  );

  modport slave (
    input  tx_data_o, tx_charisk_o, locked_o, err_o, err_cnt_o, word_cnt_o,
    output rx_valid_i, rx_data_i, rx_charisk_i, rx_disperr_i, rx_notintable_i, clear_i
  );
endinterface

// File: rtl/occ_gt_link_tester_pattern_gen.sv
// TX counter pattern with a K28.5 comma word replacing every P-th count.
module occ_gt_pattern_gen
  import occ_gt_tester_pkg::*;
#(
  parameter int g_BYTES             = 2,
  parameter int g_COMMA_PERIOD_LOG2 = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [8*g_BYTES-1:0] tx_data_o,
  output logic [g_BYTES-1:0]   tx_charisk_o
);
  localparam int W = 8 * g_BYTES;
  localparam logic [8*MAX_BYTES-1:0] COMMA_ALL_D = comma_data(g_BYTES);
  localparam logic [MAX_BYTES-1:0]   COMMA_ALL_K = comma_k(g_BYTES);
  localparam logic [W-1:0]           COMMA_D     = COMMA_ALL_D[W-1:0];
  localparam logic [g_BYTES-1:0]     COMMA_K     = COMMA_ALL_K[g_BYTES-1:0];

  // cnt_q holds the count of the word to be emitted next; the output register holds word 0 in reset.
  logic [W-1:0]       cnt_q, cnt_d;
  logic [W-1:0]       data_q, data_d;
  logic [g_BYTES-1:0] k_q, k_d;

  // Next word: comma on period boundaries, raw count otherwise.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q[g_COMMA_PERIOD_LOG2-1:0] == '0) begin
      data_d = COMMA_D;
      k_d    = COMMA_K;
    end else begin
      data_d = cnt_q;
      k_d    = '0;
    end
  end

  // Pattern registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= W'(1);
      data_q <= COMMA_D;
      k_q    <= COMMA_K;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      k_q    <= k_d;
    end
  end

  assign tx_data_o    = data_q;
  assign tx_charisk_o = k_q;
endmodule

// File: rtl/occ_gt_link_tester.sv
// Link pattern generator plus RX checker: hunts comma, locks to the counter, counts bad words.
//
// state     | meaning
// ST_HUNT   | waiting for an exact comma word
// ST_SYNC   | comma seen, expecting the word that follows it (count mod P == 1)
// ST_LOCKED | tracking the counter, checking and counting every valid word
module occ_gt_link_tester
  import occ_gt_tester_pkg::*;
#(
  parameter int g_BYTES             = 2,
  parameter int g_COMMA_PERIOD_LOG2 = 5,
  parameter int g_LOSS_THRESH       = 4,
  parameter int g_CNT_WIDTH         = 32
) (
  input logic                  clk_i,
  input logic                  rst_i,
  occ_gt_link_tester_if.master lnk
);
  localparam int W   = 8 * g_BYTES;
  localparam int PL  = g_COMMA_PERIOD_LOG2;
  localparam int BRW = $clog2(g_LOSS_THRESH + 1);
  localparam logic [8*MAX_BYTES-1:0] COMMA_ALL_D = comma_data(g_BYTES);
  localparam logic [MAX_BYTES-1:0]   COMMA_ALL_K = comma_k(g_BYTES);
  localparam logic [W-1:0]           COMMA_D     = COMMA_ALL_D[W-1:0];
  localparam logic [g_BYTES-1:0]     COMMA_K     = COMMA_ALL_K[g_BYTES-1:0];
  localparam logic [BRW-1:0]         LOSS_THRESH = BRW'(g_LOSS_THRESH);

  logic [W-1:0]       tx_data;
  logic [g_BYTES-1:0] tx_k;

  occ_gt_pattern_gen #(
    .g_BYTES             (g_BYTES),
    .g_COMMA_PERIOD_LOG2 (g_COMMA_PERIOD_LOG2)
  ) u_gen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tx_data_o    (tx_data),
    .tx_charisk_o (tx_k)
  );

  assign lnk.tx_data_o    = tx_data;
  assign lnk.tx_charisk_o = tx_k;

  chk_state_t             state_q, state_d;
  logic [W-1:0]           exp_q, exp_d;
  logic [BRW-1:0]         bad_run_q, bad_run_d, bad_run_inc;
  logic                   err_q, err_d;
  logic [g_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [g_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [W-1:0]           exp_data;
  logic [g_BYTES-1:0]     exp_k;
  logic                   rx_is_comma, rx_is_sync, rx_bad;

  // Classify the incoming word against the comma, the sync word and the expected word.
  always_comb begin
    rx_is_comma = (lnk.rx_data_i == COMMA_D) && (lnk.rx_charisk_i == COMMA_K);
    rx_is_sync  = (lnk.rx_charisk_i == '0) && (lnk.rx_data_i[PL-1:0] == PL'(1));
    if (exp_q[PL-1:0] == '0) begin
      exp_data = COMMA_D;
      exp_k    = COMMA_K;
    end else begin
      exp_data = exp_q;
      exp_k    = '0;
    end
    rx_bad = (lnk.rx_data_i != exp_data) || (lnk.rx_charisk_i != exp_k) ||
             (|lnk.rx_disperr_i) || (|lnk.rx_notintable_i);
    bad_run_inc = bad_run_q + 1'b1;
  end

  // Checker FSM and counters; everything holds while rx_valid_i is low, clear wins over counting.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    bad_run_d  = bad_run_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (lnk.rx_valid_i) begin
      case (state_q)
        ST_HUNT: begin
          if (rx_is_comma) state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (rx_is_sync) begin
            state_d   = ST_LOCKED;
            exp_d     = lnk.rx_data_i + 1'b1;
            bad_run_d = '0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          exp_d = exp_q + 1'b1;
          if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
          if (rx_bad) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (bad_run_inc == LOSS_THRESH) begin
              state_d   = ST_HUNT;
              bad_run_d = '0;
            end else begin
              bad_run_d = bad_run_inc;
            end
          end else begin
            bad_run_d = '0;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if (lnk.clear_i) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  // Checker registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_HUNT;
      exp_q      <= '0;
      bad_run_q  <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      bad_run_q  <= bad_run_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign lnk.locked_o   = (state_q == ST_LOCKED);
  assign lnk.err_o      = err_q;
  assign lnk.err_cnt_o  = err_cnt_q;
  assign lnk.word_cnt_o = word_cnt_q;
endmodule

// File: tb/tb_occ_gt_link_tester.sv
// Bench: 2-byte loopback instance for lock/fault/clear/reset sequences, 4-byte 4-bit-counter
// instance driven from a vector table through a scoreboard queue.
module tb_occ_gt_link_tester;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  occ_gt_link_tester_if #(.g_BYTES(2), .g_CNT_WIDTH(32)) ifa ();
  occ_gt_link_tester_if #(.g_BYTES(4), .g_CNT_WIDTH(4))  ifb ();

  occ_gt_link_tester #(
    .g_BYTES(2), .g_COMMA_PERIOD_LOG2(5), .g_LOSS_THRESH(4), .g_CNT_WIDTH(32)
  ) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .lnk   (ifa)
  );

  occ_gt_link_tester #(
    .g_BYTES(4), .g_COMMA_PERIOD_LOG2(5), .g_LOSS_THRESH(4), .g_CNT_WIDTH(4)
  ) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .lnk   (ifb)
  );

  logic        a_valid;
  logic [15:0] a_flip;
  logic [1:0]  a_de;
  logic        a_clr;

  assign ifa.rx_valid_i      = a_valid;
  assign ifa.rx_data_i       = ifa.tx_data_o ^ a_flip;
  assign ifa.rx_charisk_i    = ifa.tx_charisk_o;
  assign ifa.rx_disperr_i    = a_de;
  assign ifa.rx_notintable_i = 2'b00;
  assign ifa.clear_i         = a_clr;

  logic        b_valid;
  logic [31:0] b_data;
  logic [3:0]  b_k, b_de, b_nt;
  logic        b_clr;

  assign ifb.rx_valid_i      = b_valid;
  assign ifb.rx_data_i       = b_data;
  assign ifb.rx_charisk_i    = b_k;
  assign ifb.rx_disperr_i    = b_de;
  assign ifb.rx_notintable_i = b_nt;
  assign ifb.clear_i         = b_clr;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [3:0]  k;
    logic [3:0]  de;
    logic [3:0]  nt;
    logic        clr;
    logic        lk;
    logic        err;
    logic [3:0]  ec;
    logic [3:0]  wc;
  } vec_t;

  typedef struct {
    int         idx;
    logic       lk;
    logic       err;
    logic [3:0] ec;
    logic [3:0] wc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] b_word(input logic [31:0] x);
    return (x[4:0] == 5'd0) ? 32'hBC95_9595 : x;
  endfunction

  function automatic logic [3:0] b_kf(input logic [31:0] x);
    return (x[4:0] == 5'd0) ? 4'h8 : 4'h0;
  endfunction

  function automatic int sat15(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic add_vec(input logic v, input logic [31:0] d, input logic [3:0] k,
                         input logic [3:0] de, input logic [3:0] nt, input logic c,
                         input logic lk, input logic er, input int ec, input int wc);
    vec_t e;
    e.valid = v; e.data = d; e.k = k; e.de = de; e.nt = nt; e.clr = c;
    e.lk = lk; e.err = er; e.ec = 4'(ec); e.wc = 4'(wc);
    vecs.push_back(e);
  endtask

  initial begin
    int          ec;
    int          wc;
    logic [31:0] x;
    logic        found;
    exp_t        ex;

    rst = 1'b1;
    a_valid = 1'b1; a_flip = '0; a_de = '0; a_clr = 1'b0;
    b_valid = 1'b0; b_data = '0; b_k = '0; b_de = '0; b_nt = '0; b_clr = 1'b0;

    // Table for the 4-byte instance: lock near the top of the count, valid gap, wrap through
    // zero, saturating error count with interleaved good words, loss of lock, then clear.
    ec = 0; wc = 0;
    add_vec(1, 32'hBC95_9595, 4'h8, 0, 0, 0, 0, 0, ec, wc);
    add_vec(1, 32'hFFFF_FFE1, 4'h0, 0, 0, 0, 1, 0, ec, wc);
    x = 32'hFFFF_FFE2;
    wc = sat15(wc + 1);
    add_vec(1, b_word(x), b_kf(x), 0, 0, 0, 1, 0, ec, wc);
    x = x + 1;
    for (int i = 0; i < 7; i++)
      add_vec(0, 32'h1234_5678, 4'hF, 4'hF, 4'hF, 0, 1, 0, ec, wc);
    for (int i = 0; i < 32; i++) begin
      wc = sat15(wc + 1);
      add_vec(1, b_word(x), b_kf(x), 0, 0, 0, 1, 0, ec, wc);
      x = x + 1;
    end
    for (int i = 0; i < 20; i++) begin
      wc = sat15(wc + 1);
      ec = sat15(ec + 1);
      add_vec(1, b_word(x), b_kf(x), (i % 2 == 0) ? 4'h1 : 4'h0, (i % 2 == 1) ? 4'h4 : 4'h0,
              0, 1, 1, ec, wc);
      x = x + 1;
      wc = sat15(wc + 1);
      add_vec(1, b_word(x), b_kf(x), 0, 0, 0, 1, 0, ec, wc);
      x = x + 1;
    end
    for (int j = 0; j < 4; j++) begin
      wc = sat15(wc + 1);
      ec = sat15(ec + 1);
      add_vec(1, b_word(x) ^ 32'h0000_0100, b_kf(x), 0, 0, 0, (j == 3) ? 1'b0 : 1'b1, 1, ec, wc);
      x = x + 1;
    end
    add_vec(1, b_word(x), b_kf(x), 0, 0, 0, 0, 0, ec, wc);
    add_vec(1, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 0);

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_tx_data", ifa.tx_data_o, 16'hBC95);
    chk("rst_a_tx_k", ifa.tx_charisk_o, 2'b10);
    chk("rst_a_locked", ifa.locked_o, 0);
    chk("rst_a_err", ifa.err_o, 0);
    chk("rst_a_err_cnt", ifa.err_cnt_o, 0);
    chk("rst_a_word_cnt", ifa.word_cnt_o, 0);
    chk("rst_b_tx_data", ifb.tx_data_o, 32'hBC95_9595);
    chk("rst_b_tx_k", ifb.tx_charisk_o, 4'h8);

    // Loopback lock on instance A: comma at edge 1, sync word at edge 2.
    rst = 1'b0;
    tick();
    chk("a_tx_word1", ifa.tx_data_o, 16'h0001);
    chk("a_tx_k_word1", ifa.tx_charisk_o, 2'b00);
    chk("b_tx_word1", ifb.tx_data_o, 32'h1);
    chk("a_locked_after_comma", ifa.locked_o, 0);
    tick();
    chk("a_locked_after_sync", ifa.locked_o, 1);
    chk("a_word_cnt_at_lock", ifa.word_cnt_o, 0);
    repeat (9998) tick();
    chk("a_loop_locked", ifa.locked_o, 1);
    chk("a_loop_err_cnt", ifa.err_cnt_o, 0);
    chk("a_loop_word_cnt", ifa.word_cnt_o, 9998);

    // Single bit flip.
    a_flip = 16'h0040;
    tick();
    a_flip = '0;
    chk("a_flip_err", ifa.err_o, 1);
    chk("a_flip_err_cnt", ifa.err_cnt_o, 1);
    chk("a_flip_locked", ifa.locked_o, 1);
    chk("a_flip_word_cnt", ifa.word_cnt_o, 9999);
    tick();
    chk("a_after_flip_err", ifa.err_o, 0);
    chk("a_after_flip_err_cnt", ifa.err_cnt_o, 1);

    // Four consecutive bad words force loss of lock on the fourth.
    a_flip = 16'h0100;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("a_burst%0d_locked", j), ifa.locked_o, 1);
    end
    tick();
    a_flip = '0;
    chk("a_burst3_locked", ifa.locked_o, 0);
    chk("a_burst_err_cnt", ifa.err_cnt_o, 5);
    chk("a_burst_word_cnt", ifa.word_cnt_o, 10004);

    // Relock two valid words after the next comma.
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ifa.rx_data_i == 16'hBC95 && ifa.rx_charisk_i == 2'b10) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("a_relock_comma_seen", found, 1);
    tick();
    chk("a_relock_after_comma", ifa.locked_o, 0);
    tick();
    chk("a_relock_after_sync", ifa.locked_o, 1);
    chk("a_relock_err_cnt", ifa.err_cnt_o, 5);
    chk("a_relock_word_cnt", ifa.word_cnt_o, 10004);

    // Disparity error on a correct word.
    a_de = 2'b01;
    tick();
    a_de = 2'b00;
    chk("a_disperr_err", ifa.err_o, 1);
    chk("a_disperr_err_cnt", ifa.err_cnt_o, 6);
    chk("a_disperr_word_cnt", ifa.word_cnt_o, 10005);

    // Clear coincident with a bad word.
    a_flip = 16'h0001;
    a_clr  = 1'b1;
    tick();
    a_flip = '0;
    a_clr  = 1'b0;
    chk("a_clear_err_cnt", ifa.err_cnt_o, 0);
    chk("a_clear_word_cnt", ifa.word_cnt_o, 0);
    tick();
    chk("a_post_clear_word_cnt", ifa.word_cnt_o, 1);
    chk("a_post_clear_locked", ifa.locked_o, 1);

    // rx_valid_i low holds everything.
    a_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("a_idle%0d_word_cnt", i), ifa.word_cnt_o, 1);
      chk($sformatf("a_idle%0d_locked", i), ifa.locked_o, 1);
    end

    // Asynchronous reset while locked, checked before the next clock edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_a_locked", ifa.locked_o, 0);
    chk("arst_a_word_cnt", ifa.word_cnt_o, 0);
    chk("arst_a_err_cnt", ifa.err_cnt_o, 0);
    chk("arst_a_err", ifa.err_o, 0);
    chk("arst_a_tx_data", ifa.tx_data_o, 16'hBC95);
    chk("arst_a_tx_k", ifa.tx_charisk_o, 2'b10);
    tick();
    rst = 1'b0;

    // Table-driven run on instance B through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      b_valid = vecs[i].valid;
      b_data  = vecs[i].data;
      b_k     = vecs[i].k;
      b_de    = vecs[i].de;
      b_nt    = vecs[i].nt;
      b_clr   = vecs[i].clr;
      ex.idx = i; ex.lk = vecs[i].lk; ex.err = vecs[i].err; ex.ec = vecs[i].ec; ex.wc = vecs[i].wc;
      sb.push_back(ex);
      tick();
      ex = sb.pop_front();
      chk($sformatf("b_vec%0d_locked", ex.idx), ifb.locked_o, ex.lk);
      chk($sformatf("b_vec%0d_err", ex.idx), ifb.err_o, ex.err);
      chk($sformatf("b_vec%0d_err_cnt", ex.idx), ifb.err_cnt_o, ex.ec);
      chk($sformatf("b_vec%0d_word_cnt", ex.idx), ifb.word_cnt_o, ex.wc);
    end
    b_valid = 1'b0;
    b_clr   = 1'b0;
    chk("b_scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
